// File: rtl/ins_fetch_unit_if.sv
// Fetch-stage bus: decode back-pressure, branch redirect, instruction cache
// request/response, and the instruction stream delivered to decode.
interface ins_fetch_unit_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     STALL;
    logic                     BRANCH_TAKEN;
    logic [ADDRESS_WIDTH-1:0] BRANCH_ADDRESS;
    logic                     CACHE_READY;
    logic [DATA_WIDTH-1:0]    CACHE_INSTRUCTION;
    logic                     CACHE_READ;
    logic [ADDRESS_WIDTH-1:0] CACHE_ADDRESS;
    logic [ADDRESS_WIDTH-1:0] PC;
    logic [DATA_WIDTH-1:0]    INSTRUCTION;
    logic                     INSTRUCTION_VALID;

    // Environment side: decode, execute and the instruction cache.
    modport master (
        output STALL, BRANCH_TAKEN, BRANCH_ADDRESS, CACHE_READY, CACHE_INSTRUCTION,
        input  CACHE_READ, CACHE_ADDRESS, PC, INSTRUCTION, INSTRUCTION_VALID
    );

    // Fetch unit side.
    modport slave (
        input  STALL, BRANCH_TAKEN, BRANCH_ADDRESS, CACHE_READY, CACHE_INSTRUCTION,
        output CACHE_READ, CACHE_ADDRESS, PC, INSTRUCTION, INSTRUCTION_VALID
    );
endinterface

// File: rtl/ins_fetch_unit.sv
// RV32I instruction fetch: owns the PC, requests words from the I-cache and
// feeds decode through a registered output stage with a one-entry hold buffer.
module ins_fetch_unit #(
    parameter int                       ADDRESS_WIDTH   = 32,
    parameter int                       DATA_WIDTH      = 32,
    parameter logic [ADDRESS_WIDTH-1:0] PC_RESET        = '0,
    parameter int                       PC_INCREMENT    = 4,
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTRUCTION = DATA_WIDTH'(32'h00000013)
) (
    input  logic          CLK,
    input  logic          RESET,
    ins_fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD} state_t;

    state_t                   state_reg;
    logic [ADDRESS_WIDTH-1:0] pc_reg;
    logic [ADDRESS_WIDTH-1:0] pc_inc_next;
    logic [ADDRESS_WIDTH-1:0] branch_target_next;
    logic [DATA_WIDTH-1:0]    out_instr_reg;
    logic [ADDRESS_WIDTH-1:0] out_pc_reg;
    logic                     out_valid_reg;
    logic [DATA_WIDTH-1:0]    hold_instr_reg;
    logic [ADDRESS_WIDTH-1:0] hold_pc_reg;
    logic                     cache_read_reg;
    logic                     unused_branch_lsbs;

    assign pc_inc_next        = pc_reg + ADDRESS_WIDTH'(PC_INCREMENT);
    // Targets are word aligned; the low address bits from execute are dropped.
    assign branch_target_next = {bus.BRANCH_ADDRESS[ADDRESS_WIDTH-1:2], 2'b00};
    assign unused_branch_lsbs = ^bus.BRANCH_ADDRESS[1:0];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= PC_RESET;
            out_instr_reg  <= NOP_INSTRUCTION;
            out_pc_reg     <= '0;
            out_valid_reg  <= 1'b0;
            hold_instr_reg <= NOP_INSTRUCTION;
            hold_pc_reg    <= '0;
            cache_read_reg <= 1'b0;
        end else if (bus.BRANCH_TAKEN) begin
            // Flush beats stall: the output bubble is forced even if decode is stalled.
            state_reg      <= ST_FETCH;
            pc_reg         <= branch_target_next;
            out_instr_reg  <= NOP_INSTRUCTION;
            out_valid_reg  <= 1'b0;
            cache_read_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg      <= ST_FETCH;
                    cache_read_reg <= 1'b1;
                end
                ST_FETCH: begin
                    if (bus.CACHE_READY) begin
                        pc_reg <= pc_inc_next;
                        if (bus.STALL) begin
                            hold_instr_reg <= bus.CACHE_INSTRUCTION;
                            hold_pc_reg    <= pc_reg;
                            state_reg      <= ST_HOLD;
                            cache_read_reg <= 1'b0;
                        end else begin
                            out_instr_reg <= bus.CACHE_INSTRUCTION;
                            out_pc_reg    <= pc_reg;
                            out_valid_reg <= 1'b1;
                        end
                    end else if (!bus.STALL) begin
                        out_instr_reg <= NOP_INSTRUCTION;
                        out_valid_reg <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!bus.STALL) begin
                        out_instr_reg  <= hold_instr_reg;
                        out_pc_reg     <= hold_pc_reg;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= ST_FETCH;
                        cache_read_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    cache_read_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CACHE_READ        = cache_read_reg;
    assign bus.CACHE_ADDRESS     = pc_reg;
    assign bus.PC                = out_pc_reg;
    assign bus.INSTRUCTION       = out_instr_reg;
    assign bus.INSTRUCTION_VALID = out_valid_reg;
endmodule

// File: tb/tb_ins_fetch_unit.sv
// Bench for ins_fetch_unit: two instances (PC_RESET 0 and FFFFFFF8) share the
// stimulus; a queue-style fetch model predicts every output on every cycle.
module tb_ins_fetch_unit;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] ba;
    logic        rdy;

    int checks;
    int errors;

    ins_fetch_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    ins_fetch_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h3C00_0000;
    endfunction

    function automatic logic [31:0] reset_pc(input int k);
        return (k == 0) ? 32'h00000000 : 32'hFFFFFFF8;
    endfunction

    assign bus_a.STALL             = stall;
    assign bus_a.BRANCH_TAKEN      = br;
    assign bus_a.BRANCH_ADDRESS    = ba;
    assign bus_a.CACHE_READY       = rdy;
    assign bus_a.CACHE_INSTRUCTION = word_of(bus_a.CACHE_ADDRESS);
    assign bus_b.STALL             = stall;
    assign bus_b.BRANCH_TAKEN      = br;
    assign bus_b.BRANCH_ADDRESS    = ba;
    assign bus_b.CACHE_READY       = rdy;
    assign bus_b.CACHE_INSTRUCTION = word_of(bus_b.CACHE_ADDRESS);

    ins_fetch_unit #(.PC_RESET(32'h00000000)) dut_a (.CLK(clk), .RESET(rst), .bus(bus_a));
    ins_fetch_unit #(.PC_RESET(32'hFFFFFFF8)) dut_b (.CLK(clk), .RESET(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: next address to fetch, a single-slot queue of captured words,
    // the word currently presented to decode, and the post-reset dead cycle.
    logic [31:0] m_pc    [2];
    logic        m_qv    [2];
    logic [31:0] m_qi    [2];
    logic [31:0] m_qp    [2];
    logic [31:0] m_out_i [2];
    logic [31:0] m_out_p [2];
    logic        m_out_v [2];
    logic        m_dead  [2];

    task automatic model_step(input int k);
        if (rst) begin
            m_pc[k] = reset_pc(k); m_qv[k] = 1'b0; m_dead[k] = 1'b1;
            m_out_i[k] = NOP; m_out_p[k] = 32'h0; m_out_v[k] = 1'b0;
        end else if (br) begin
            m_pc[k] = {ba[31:2], 2'b00}; m_qv[k] = 1'b0; m_dead[k] = 1'b0;
            m_out_i[k] = NOP; m_out_v[k] = 1'b0;
        end else if (m_dead[k]) begin
            m_dead[k] = 1'b0;
        end else begin
            // A word enters the queue only when the slot is free; decode drains it.
            if (!m_qv[k] && rdy) begin
                m_qv[k] = 1'b1; m_qi[k] = word_of(m_pc[k]); m_qp[k] = m_pc[k];
                m_pc[k] = m_pc[k] + 32'd4;
            end
            if (!stall) begin
                if (m_qv[k]) begin
                    m_out_i[k] = m_qi[k]; m_out_p[k] = m_qp[k]; m_out_v[k] = 1'b1;
                    m_qv[k] = 1'b0;
                end else begin
                    m_out_i[k] = NOP; m_out_v[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_dut(input int k, input logic v, input logic [31:0] i,
                               input logic [31:0] p, input logic r, input logic [31:0] a);
        chk1 ($sformatf("dut%0d_valid", k), v, m_out_v[k]);
        chk32($sformatf("dut%0d_instr", k), i, m_out_i[k]);
        chk32($sformatf("dut%0d_pc", k), p, m_out_p[k]);
        chk1 ($sformatf("dut%0d_cache_read", k), r, !m_dead[k] && !m_qv[k]);
        chk32($sformatf("dut%0d_cache_addr", k), a, m_pc[k]);
    endtask

    // One clock: apply inputs, advance the model on the edge, compare at negedge.
    task automatic cyc(input logic r, input logic s, input logic b,
                       input logic [31:0] addr, input logic ry);
        rst = r; stall = s; br = b; ba = addr; rdy = ry;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_dut(0, bus_a.INSTRUCTION_VALID, bus_a.INSTRUCTION, bus_a.PC,
                    bus_a.CACHE_READ, bus_a.CACHE_ADDRESS);
        compare_dut(1, bus_b.INSTRUCTION_VALID, bus_b.INSTRUCTION, bus_b.PC,
                    bus_b.CACHE_READ, bus_b.CACHE_ADDRESS);
        if (bus_a.INSTRUCTION_VALID === 1'b1 && !r)
            $display("txn t=%0t pc=%08h instr=%08h", $time, bus_a.PC, bus_a.INSTRUCTION);
    endtask

    logic [31:0] wrap_exp [4];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; stall = 1'b0; br = 1'b0; ba = 32'h0; rdy = 1'b1;
        wrap_exp = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};

        // Wrap-around on the second instance, continuous ready.
        repeat (3) cyc(1, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 32'h0, 1);
            chk32("wrap_pc", bus_b.PC, wrap_exp[i]);
            chk1 ("wrap_valid", bus_b.INSTRUCTION_VALID, 1'b1);
        end

        // Reset, dead cycle, then streaming from 0.
        repeat (3) begin
            cyc(1, 0, 0, 32'h0, 1);
            chk1 ("rst_valid", bus_a.INSTRUCTION_VALID, 1'b0);
            chk32("rst_instr", bus_a.INSTRUCTION, NOP);
            chk1 ("rst_read", bus_a.CACHE_READ, 1'b0);
        end
        cyc(0, 0, 0, 32'h0, 1);
        chk1 ("idle_then_read", bus_a.CACHE_READ, 1'b1);
        chk32("first_addr", bus_a.CACHE_ADDRESS, 32'h0);
        cyc(0, 0, 0, 32'h0, 1);
        chk32("stream_pc0", bus_a.PC, 32'h0);
        chk32("stream_instr0", bus_a.INSTRUCTION, word_of(32'h0));
        cyc(0, 0, 0, 32'h0, 1);
        chk32("stream_pc4", bus_a.PC, 32'h4);

        // Stall for 3 cycles with the word for 8 ready.
        repeat (3) begin
            cyc(0, 1, 0, 32'h0, 1);
            chk32("stall_pc_held", bus_a.PC, 32'h4);
            chk1 ("hold_no_read", bus_a.CACHE_READ, 1'b0);
        end
        cyc(0, 0, 0, 32'h0, 1);
        chk32("hold_release_pc", bus_a.PC, 32'h8);
        chk1 ("hold_release_valid", bus_a.INSTRUCTION_VALID, 1'b1);
        chk32("next_req", bus_a.CACHE_ADDRESS, 32'hC);
        cyc(0, 0, 0, 32'h0, 1);
        chk32("pc12", bus_a.PC, 32'hC);

        // Cache miss for 2 cycles at 16.
        repeat (2) begin
            cyc(0, 0, 0, 32'h0, 0);
            chk1 ("bubble_valid", bus_a.INSTRUCTION_VALID, 1'b0);
            chk32("bubble_instr", bus_a.INSTRUCTION, NOP);
            chk32("miss_addr", bus_a.CACHE_ADDRESS, 32'h10);
        end
        cyc(0, 0, 0, 32'h0, 1);
        chk32("pc16", bus_a.PC, 32'h10);

        // Branch while holding under stall.
        cyc(0, 1, 0, 32'h0, 1);
        cyc(0, 1, 1, 32'h00000103, 1);
        chk1 ("flush_valid", bus_a.INSTRUCTION_VALID, 1'b0);
        chk32("branch_addr", bus_a.CACHE_ADDRESS, 32'h100);
        cyc(0, 0, 0, 32'h0, 1);
        chk32("branch_pc0", bus_a.PC, 32'h100);
        cyc(0, 0, 0, 32'h0, 1);
        chk32("branch_pc1", bus_a.PC, 32'h104);

        // Reset coincident with branch and ready.
        cyc(1, 0, 1, 32'h00000200, 1);
        chk1 ("rst_wins_valid", bus_a.INSTRUCTION_VALID, 1'b0);
        chk1 ("rst_wins_read", bus_a.CACHE_READ, 1'b0);
        chk32("rst_wins_addr", bus_a.CACHE_ADDRESS, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(99) < 2), ($urandom_range(99) < 30),
                ($urandom_range(99) < 5), $urandom, ($urandom_range(99) < 70));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ins_fetch_unit.md
Name: ins_fetch_unit

Overview:
- Instruction fetch stage of the RV32I pipeline, sitting directly upstream of the instruction decoder.
- Owns the program counter and issues read requests to the instruction cache.
- Delivers {INSTRUCTION, PC, INSTRUCTION_VALID} to decode through an output pipeline register, with stall back-pressure, branch redirect/flush, and a one-entry hold buffer so a returned cache word is never lost while decode is stalled.

Parameters:
- ADDRESS_WIDTH, 32, width of PC and cache address.
- DATA_WIDTH, 32, instruction width.
- PC_RESET, 32'h00000000, PC value loaded on reset.
- PC_INCREMENT, 4, sequential PC step in bytes.
- NOP_INSTRUCTION, 32'h00000013, bubble encoding (addi x0,x0,0) driven when invalid.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- STALL  input  1  decode cannot accept; output register holds.
- BRANCH_TAKEN  input  1  redirect request from execute; flushes fetch.
- BRANCH_ADDRESS  input  ADDRESS_WIDTH  redirect target; bits [1:0] are ignored and treated as 0.
- CACHE_READY  input  1  CACHE_INSTRUCTION is valid for the current CACHE_ADDRESS this cycle.
- CACHE_INSTRUCTION  input  DATA_WIDTH  word returned by the instruction cache.
- CACHE_READ  output  1  read request to the cache.
- CACHE_ADDRESS  output  ADDRESS_WIDTH  request address; equals the internal PC_REG.
- PC  output  ADDRESS_WIDTH  address of INSTRUCTION.
- INSTRUCTION  output  DATA_WIDTH  instruction to the decoder.
- INSTRUCTION_VALID  output  1  INSTRUCTION/PC hold a real instruction.

Behaviour:
- Reset (sampled on CLK edge, overrides everything, including mid-request or mid-hold):
  - PC_REG=PC_RESET.
  - INSTRUCTION=NOP_INSTRUCTION, PC=0, INSTRUCTION_VALID=0.
  - CACHE_READ=0.
  - Hold buffer cleared; state=IDLE.
- State IDLE: CACHE_READ=0; unconditionally go to FETCH next cycle. This gives exactly one dead cycle after reset deasserts.
- State FETCH: CACHE_READ=1, CACHE_ADDRESS=PC_REG (registered, stable until the cycle after capture).
  - CACHE_READY=1, STALL=0: output register <= {CACHE_INSTRUCTION, PC_REG, 1}; PC_REG += PC_INCREMENT; stay FETCH.
  - CACHE_READY=1, STALL=1: hold buffer <= {CACHE_INSTRUCTION, PC_REG}; PC_REG += PC_INCREMENT; output register unchanged; go HOLD.
  - CACHE_READY=0, STALL=0: output register <= {NOP_INSTRUCTION, PC unchanged, 0} (bubble); stay FETCH.
  - CACHE_READY=0, STALL=1: output register unchanged; stay FETCH.
- State HOLD: CACHE_READ=0; PC_REG unchanged.
  - STALL=1: everything held.
  - STALL=0: output register <= {hold instruction, hold PC, 1}; go FETCH. The next request is issued that same following cycle.
- Branch (BRANCH_TAKEN=1, priority below RESET, above all else, in any state):
  - PC_REG <= {BRANCH_ADDRESS[31:2], 2'b00}.
  - Output register <= {NOP_INSTRUCTION, PC unchanged, 0} even if STALL=1; the flush overrides the stall.
  - Hold buffer discarded; any CACHE_READY word that cycle is discarded; next state=FETCH.
  - First redirected instruction can appear one cycle after the cache accepts the new address.
- Throughput and latency:
  - One instruction per cycle when CACHE_READY=1 continuously and STALL=0.
  - Capture-to-output latency is 1 cycle.
- Arithmetic: PC increments modulo 2^ADDRESS_WIDTH; 32'hFFFFFFFC + 4 wraps to 32'h00000000 with no flag.
- Invariants:
  - INSTRUCTION_VALID=0 implies INSTRUCTION=NOP_INSTRUCTION.
  - No instruction is duplicated or dropped except by BRANCH_TAKEN or RESET.
  - At most one outstanding request; the cache must hold CACHE_READY meaningful only for the presented address.

Test Plan:
- Reset held 3 cycles, then released with CACHE_READY=1, STALL=0 → during reset VALID=0, INSTRUCTION=32'h13, CACHE_READ=0; one IDLE cycle; then CACHE_ADDRESS 0,4,8…; outputs PC=0,4,8 with VALID=1 on consecutive cycles, INSTRUCTION matching the cache words.
- Streaming with STALL=1 for 3 cycles while CACHE_READY=1 at PC=8 → output stays at PC=4; word for 8 captured in hold buffer; CACHE_READ=0 during HOLD; on STALL release PC=8 appears VALID=1, next request is 12; no duplicate or missing PC.
- CACHE_READY low for 2 cycles at PC=16 → two bubbles (VALID=0, INSTRUCTION=32'h13), CACHE_ADDRESS held at 16, then PC=16 delivered.
- BRANCH_TAKEN=1 with BRANCH_ADDRESS=32'h00000103 while in HOLD with STALL=1 → next cycle VALID=0, hold word dropped, CACHE_ADDRESS=32'h00000100; subsequent outputs PC=0x100, 0x104.
- PC_RESET=32'hFFFFFFF8, continuous CACHE_READY → outputs PC=FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- RESET asserted in the same cycle as BRANCH_TAKEN and CACHE_READY during FETCH → reset wins: PC_REG=PC_RESET, VALID=0, state IDLE.
